// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD display controller: FSM states, frame geometry
// and the packing of decimal digits into the display's 32-bit frame word.
package bcd_disp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int unsigned WORD_BITS = 32;
    localparam int unsigned BIT_CNT_W = $clog2(WORD_BITS);
    localparam int unsigned DIV_W     = 8;
    localparam int unsigned VALUE_W   = 8;

    // The display interprets a frame of all-zero digits as "blank" only via this code.
    localparam logic [WORD_BITS-1:0] BLANK_WORD = 32'h0000_0001;

    function automatic logic [WORD_BITS-1:0] pack_digits(
        input logic [3:0] hundreds,
        input logic [3:0] tens,
        input logic [3:0] ones
    );
        return {12'b0, hundreds, 4'b0, tens, 4'b0, ones};
    endfunction

endpackage

// File: rtl/bcd_display_ctrl_bcd.sv
// Combinational 8-bit binary to three-digit BCD converter (shift-and-add-3).
module bcd_display_ctrl_bcd
    import bcd_disp_pkg::*;
(
    input  logic [VALUE_W-1:0] value,
    output logic [3:0]         hundreds,
    output logic [3:0]         tens,
    output logic [3:0]         ones
);

    // acc[19:8] holds the BCD digits, acc[7:0] the binary bits still to shift in.
    logic [19:0] acc;

    always_comb begin
        acc = {12'b0, value};
        for (int unsigned i = 0; i < VALUE_W; i++) begin
            if (acc[11:8] >= 4'd5) begin
                acc[11:8] = acc[11:8] + 4'd3;
            end
            if (acc[15:12] >= 4'd5) begin
                acc[15:12] = acc[15:12] + 4'd3;
            end
            acc = acc << 1;
        end
    end

    assign hundreds = acc[19:16];
    assign tens     = acc[15:12];
    assign ones     = acc[11:8];

endmodule

// File: rtl/bcd_display_ctrl.sv
// Two-requester arbiter feeding a mode-0 SPI transmitter that sends each accepted
// binary value to the display as a 32-bit BCD frame.
module bcd_display_ctrl
    import bcd_disp_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    input  logic [VALUE_W-1:0] req_value0,
    input  logic [VALUE_W-1:0] req_value1,
    output logic [1:0]         req_ready,
    output logic               spi_cs_n,
    output logic               spi_sclk,
    output logic               spi_mosi,
    output logic               busy,
    output logic               done,
    output logic               done_src
);

    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(WORD_BITS - 1);

    state_t               state;
    logic                 last_grant;
    logic [VALUE_W-1:0]   value_q;
    logic                 src_q;
    logic [WORD_BITS-1:0] shreg;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;

    logic                 grant_idx;
    logic                 xfer;
    logic [3:0]           hundreds;
    logic [3:0]           tens;
    logic [3:0]           ones;
    logic [WORD_BITS-1:0] bcd_word;

    bcd_display_ctrl_bcd u_bcd (
        .value    (value_q),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones)
    );

    assign bcd_word = (value_q == '0) ? BLANK_WORD : pack_digits(hundreds, tens, ones);

    // Ties go to the requester that did not win the previous transfer.
    always_comb begin
        req_ready = '0;
        grant_idx = 1'b0;
        if (state == ST_IDLE) begin
            case (req_valid)
                2'b01: begin
                    req_ready = 2'b01;
                    grant_idx = 1'b0;
                end
                2'b10: begin
                    req_ready = 2'b10;
                    grant_idx = 1'b1;
                end
                2'b11: begin
                    grant_idx = ~last_grant;
                    req_ready = last_grant ? 2'b01 : 2'b10;
                end
                default: begin
                    req_ready = '0;
                    grant_idx = 1'b0;
                end
            endcase
        end
    end

    assign xfer = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            value_q    <= '0;
            src_q      <= 1'b0;
            shreg      <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            spi_cs_n   <= 1'b1;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_src   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        value_q    <= grant_idx ? req_value1 : req_value0;
                        src_q      <= grant_idx;
                        last_grant <= grant_idx;
                        spi_cs_n   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shreg    <= bcd_word;
                    spi_mosi <= bcd_word[WORD_BITS-1];
                    spi_sclk <= 1'b0;
                    div_cnt  <= '0;
                    bit_cnt  <= '0;
                    state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                        end else begin
                            // Falling edge: advance to the next bit so it is stable before the next rise.
                            spi_sclk <= 1'b0;
                            shreg    <= shreg << 1;
                            if (bit_cnt == BIT_LAST) begin
                                spi_mosi <= 1'b0;
                                state    <= ST_HOLD;
                            end else begin
                                spi_mosi <= shreg[WORD_BITS-2];
                                bit_cnt  <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        spi_cs_n <= 1'b1;
                        done     <= 1'b1;
                        done_src <= src_q;
                        state    <= ST_DONE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    spi_cs_n <= 1'b1;
                    spi_sclk <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
